// File: rtl/dispense_pkg.sv
// Shared types and defaults for the candy-dispense arbiter.
// Holds the FSM state encoding and default pulse/gap lengths.
package dispense_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } disp_state_t;

    localparam int DEF_PULSE_CYCLES = 8;
    localparam int DEF_GAP_CYCLES   = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping around; returns one-hot select, its index and any_req.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] sel,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    logic             hit;
    logic [IDX_W-1:0] k;

    always_comb begin
        sel = '0;
        idx = '0;
        hit = 1'b0;
        k   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!hit && req[k]) begin
                hit    = 1'b1;
                sel[k] = 1'b1;
                idx    = k;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/dispense_arbiter.sv
// Round-robin motor arbiter for NUM_REQ vending front-ends.
// Stock tracking, empty, nak and refill exist only with STOCK_TRACK_EN.
module dispense_arbiter
    import dispense_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int STOCK_W      = 8,
    parameter int STOCK_INIT   = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               refill,
    input  logic [STOCK_W-1:0] refill_qty,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] nak,
    output logic               motor_on,
    output logic [STOCK_W-1:0] stock,
    output logic               empty,
    output logic               busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CMAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W = $clog2(CMAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    disp_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   rr_ptr, owner_q;
    logic [NUM_REQ-1:0] grant_d, done_d, nak_d;
    logic [NUM_REQ-1:0] pick_sel;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_req, can_grant, take, dec;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .sel     (pick_sel),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = '0;
        done_d  = '0;
        nak_d   = '0;
        take    = 1'b0;
        dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (can_grant) begin
                        state_d = PULSE;
                        cnt_d   = PULSE_LOAD;
                        grant_d = pick_sel;
                        take    = 1'b1;
                    end else begin
                        nak_d = req;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                    done_d  = NUM_REQ'(1) << owner_q;
                    dec     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_ptr  <= '0;
            owner_q <= '0;
            grant   <= '0;
            done    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant   <= grant_d;
            done    <= done_d;
            if (take) begin
                owner_q <= pick_idx;
                rr_ptr  <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    assign motor_on = (state_q == PULSE);
    assign busy     = (state_q != IDLE);

`ifdef STOCK_TRACK_EN
    logic [STOCK_W-1:0] stock_q;
    logic [STOCK_W:0]   sum;

    // Refill and decrement may coincide; widen by one bit to catch overflow.
    always_comb begin
        sum = {1'b0, stock_q}
            + (refill ? {1'b0, refill_qty} : '0)
            - (STOCK_W + 1)'(dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stock_q <= STOCK_W'(STOCK_INIT);
            nak     <= '0;
        end else begin
            stock_q <= sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
            nak     <= nak_d;
        end
    end

    assign can_grant = (stock_q != '0);
    assign stock     = stock_q;
    assign empty     = (stock_q == '0);
`else
    logic unused_stock;

    assign unused_stock = ^{refill, refill_qty, nak_d, dec};
    assign can_grant    = 1'b1;
    assign stock        = STOCK_W'(STOCK_INIT);
    assign empty        = 1'b0;
    assign nak          = '0;
`endif

endmodule
